mem_arbiter_2p: RTL

//  Shares one mem_mod instance between two requesters (port 0, port 1).

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arbiter_2p_rr_arb2.sv | 40 ++++
 rtl/mem_arbiter_2p.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: default geometry,
// port-id encoding and the read-response tag carried alongside each command.
package mem_arb_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_ADDR_DEF   = 4;
  localparam int PORT_ID_W      = 1;
  localparam int CMD_WE_W       = 1;
  localparam int RSP_LAT        = 2;

  typedef logic [PORT_ID_W-1:0] port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  typedef struct packed {
    logic     vld;
    port_id_t port;
    logic     oor;
  } rsp_tag_t;

  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/mem_arbiter_2p_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant
// pointer that only moves when a grant is actually taken.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output port_id_t o_gnt_port,
  output logic     o_accept
);

  port_id_t r_last;
  port_id_t w_pref;

  assign w_pref = other_port(r_last);

  always_comb begin
    o_gnt = 2'b00;
    if (!rst) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (w_pref == PORT1) ? 2'b10 : 2'b01;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  assign o_accept   = |o_gnt;
  assign o_gnt_port = o_gnt[1] ? PORT1 : PORT0;

  // Reset to PORT1 so port 0 wins the first contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last <= PORT1;
    else if (o_accept) r_last <= o_gnt_port;
  end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Shares one mem_mod between two requesters: round-robin grant, registered
// issue stage, and a fixed two-deep tag pipe that routes read data back.
module mem_arbiter_2p
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_ADDR   = MAX_ADDR_DEF,
  parameter int ADDRSIZE   = $clog2(MAX_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic                  req_we_0,
  input  logic [ADDRSIZE-1:0]   req_addr_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  output logic                  rsp_valid_0,
  output logic [DATA_WIDTH-1:0] rsp_data_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic                  req_we_1,
  input  logic [ADDRSIZE-1:0]   req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  rsp_valid_1,
  output logic [DATA_WIDTH-1:0] rsp_data_1,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDRSIZE-1:0]   mem_wr_addr,
  output logic [ADDRSIZE-1:0]   mem_rd_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam logic [ADDRSIZE:0] LP_LIMIT = MAX_ADDR[ADDRSIZE:0];

  logic [1:0]            w_gnt;
  port_id_t              w_sel;
  logic                  w_acc;
  logic                  w_we;
  logic [ADDRSIZE-1:0]   w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_oor;
  logic                  w_wr_issue;
  logic                  w_rd_issue;

  logic                  r_wr_en;
  logic                  r_rd_en;
  logic [ADDRSIZE-1:0]   r_wr_addr;
  logic [ADDRSIZE-1:0]   r_rd_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  rsp_tag_t              r_tag [RSP_LAT];

  rsp_tag_t              w_tail;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      ({req_valid_1, req_valid_0}),
    .o_gnt      (w_gnt),
    .o_gnt_port (w_sel),
    .o_accept   (w_acc)
  );

  assign req_ready_0 = w_gnt[0];
  assign req_ready_1 = w_gnt[1];

  assign w_we    = (w_sel == PORT1) ? req_we_1    : req_we_0;
  assign w_addr  = (w_sel == PORT1) ? req_addr_1  : req_addr_0;
  assign w_wdata = (w_sel == PORT1) ? req_wdata_1 : req_wdata_0;

  // Out-of-range commands are still accepted; they just never reach mem_mod.
  assign w_oor      = ({1'b0, w_addr} >= LP_LIMIT);
  assign w_wr_issue = w_acc &  w_we & ~w_oor;
  assign w_rd_issue = w_acc & ~w_we & ~w_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_wr_issue;
      r_rd_en <= w_rd_issue;
      if (w_wr_issue) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_wdata;
      end
      if (w_rd_issue) r_rd_addr <= w_addr;
    end
  end

  assign mem_wr_en   = r_wr_en;
  assign mem_rd_en   = r_rd_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_rd_addr = r_rd_addr;
  assign mem_wr_data = r_wr_data;

  // Tag pipe mirrors issue + mem_mod read latency; reset flushes pending reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{vld: w_acc & ~w_we, port: w_sel, oor: w_oor};
      for (int i = 1; i < RSP_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tail     = r_tag[RSP_LAT-1];
  assign w_rsp_data = w_tail.oor ? '0 : mem_rd_data;

  assign rsp_valid_0 = w_tail.vld & (w_tail.port == PORT0);
  assign rsp_valid_1 = w_tail.vld & (w_tail.port == PORT1);
  assign rsp_data_0  = rsp_valid_0 ? w_rsp_data : '0;
  assign rsp_data_1  = rsp_valid_1 ? w_rsp_data : '0;

endmodule
